fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of a fifo instance among NUM_REQ requesters. Each requester presents a word with a req/ack handshake. The arbiter grants one requester per cycle, allows bursts of up to BURST_MAX consecutive words per owner, and drives a registered fifo write. It sits directly in front of a fifo whose full flag leaves at least 2 entries of slack (MAX_ITEMS <= DEPTH-3).

---
 rtl/fifo_write_arbiter_if.sv | 19 +
 rtl/fifo_write_arbiter.sv | 91 +++++++++
 tb/tb_fifo_write_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if: requester handshake and fifo write bundle for fifo_write_arbiter
// master: arbiter side (takes req/data_in/fifo_full, drives ack and the registered write)
// slave: requester/fifo side
interface fifo_write_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = 2
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       ack;
  logic                     fifo_full;
  logic                     fifo_we;
  logic [WIDTH-1:0]         fifo_data_w;
  logic [REQ_BITS-1:0]      grant_id;
  logic                     busy;
  modport master(input req, data_in, fifo_full, output ack, fifo_we, fifo_data_w, grant_id, busy);
  modport slave(output req, data_in, fifo_full, input ack, fifo_we, fifo_data_w, grant_id, busy);
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin, burst-limited sharing of one fifo write port
// clk/reset_n: rising-edge clock, async active-low reset
// bus.req/data_in/ack: per-requester word handshake, ack is combinational one-hot
// bus.fifo_full: stalls all acks; bus.fifo_we/fifo_data_w/grant_id: registered write
// bus.busy: high while a requester owns the port
module fifo_write_arbiter #(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int REQ_BITS  = 2,
  parameter int BURST_MAX = 4,
  parameter int CNT_BITS  = 3
) (
  input logic clk,
  input logic reset_n,
  fifo_write_arbiter_if.master bus
);
  typedef enum logic {IDLE, OWN} state_t;
  localparam logic [CNT_BITS-1:0] BMAX = CNT_BITS'(BURST_MAX);
  state_t state_q, state_d;
  logic [REQ_BITS-1:0] owner_q, owner_d, rr_last_q, rr_last_d, pick, idx, ack_idx, gid_q;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic pick_vld, keep, ack_vld, fifo_we_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] words [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = bus.data_in[i*WIDTH +: WIDTH];
  end
  // descending scan so the nearest requester after rr_last is assigned last and wins
  always_comb begin
    pick_vld = 1'b0;
    pick = '0;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = REQ_BITS'((int'(rr_last_q) + k) % NUM_REQ);
      if (bus.req[idx]) begin
        pick_vld = 1'b1;
        pick = idx;
      end
    end
  end
  // in OWN, rr_last equals owner, so the same scan re-arbitrates from owner+1
  assign keep    = state_q == OWN && bus.req[owner_q] && cnt_q < BMAX;
  assign ack_vld = !bus.fifo_full && (keep || pick_vld);
  assign ack_idx = keep ? owner_q : pick;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rr_last_q <= REQ_BITS'(NUM_REQ - 1);
      cnt_q     <= '0;
      fifo_we_q <= 1'b0;
      data_q    <= '0;
      gid_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
      fifo_we_q <= ack_vld;
      if (ack_vld) begin
        data_q <= words[ack_idx];
        gid_q  <= ack_idx;
      end
    end
  end
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    if (!bus.fifo_full) begin
      if (keep) cnt_d = cnt_q + 1'b1;
      else if (pick_vld) begin
        state_d   = BURST_MAX == 1 ? IDLE : OWN;
        owner_d   = pick;
        rr_last_d = pick;
        cnt_d     = BURST_MAX == 1 ? '0 : CNT_BITS'(1);
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end
  always_comb begin
    bus.ack  = (reset_n && ack_vld) ? (NUM_REQ'(1) << ack_idx) : '0;
    bus.busy = state_q == OWN;
  end
  assign bus.fifo_we     = fifo_we_q;
  assign bus.fifo_data_w = data_q;
  assign bus.grant_id    = gid_q;
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: vector table, corner sequences and random traffic against a reference model
module tb_fifo_write_arbiter;
  localparam int BM = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  fifo_write_arbiter_if bus();
  fifo_write_arbiter dut(.clk(clk), .reset_n(reset_n), .bus(bus));
  int n_chk = 0, n_fail = 0;
  logic [31:0] words [4];
  bit m_busy, m_we;
  int m_owner, m_cnt, m_last, m_gid, last_w;
  logic [31:0] m_data;
  typedef struct { logic [3:0] req; bit full; logic [3:0] ack; int gid; bit busy; } vec_t;
  vec_t tbl [12];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  function automatic void m_reset();
    m_busy = 0; m_we = 0; m_owner = 0; m_cnt = 0; m_last = 3; m_gid = 0; m_data = 0;
  endfunction
  function automatic int m_pick(logic [3:0] r, bit f);
    int base;
    if (f) return -1;
    if (m_busy && r[m_owner] && m_cnt < BM) return m_owner;
    base = m_busy ? m_owner : m_last;
    for (int k = 1; k <= 4; k++) if (r[(base + k) % 4]) return (base + k) % 4;
    return -1;
  endfunction
  task automatic cycle(input logic [3:0] r, input bit f, output logic [3:0] a);
    int w;
    bit cont;
    bus.req = r;
    bus.fifo_full = f;
    bus.data_in = {words[3], words[2], words[1], words[0]};
    #1;
    a = bus.ack;
    w = m_pick(r, f);
    cont = !f && m_busy && r[m_owner] && m_cnt < BM;
    chk("ack", 32'(bus.ack), (w < 0) ? 32'd0 : (32'd1 << w));
    @(posedge clk);
    if (w >= 0) begin
      m_data = words[w];
      m_gid = w;
      if (cont) m_cnt++;
      else begin
        m_busy = 1; m_owner = w; m_last = w; m_cnt = 1;
      end
    end else if (!f) begin
      m_busy = 0; m_cnt = 0;
    end
    m_we = w >= 0;
    last_w = w;
    #1;
    chk("fifo_we", 32'(bus.fifo_we), 32'(m_we));
    chk("fifo_data_w", bus.fifo_data_w, m_data);
    chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
    chk("busy", 32'(bus.busy), 32'(m_busy));
  endtask
  task automatic check_reset_outputs(input string n);
    chk({n, "_we"}, 32'(bus.fifo_we), 32'd0);
    chk({n, "_gid"}, 32'(bus.grant_id), 32'd0);
    chk({n, "_busy"}, 32'(bus.busy), 32'd0);
    chk({n, "_ack"}, 32'(bus.ack), 32'd0);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    chk("reset_data", bus.fifo_data_w, 32'd0);
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask
  initial begin
    logic [3:0] a, r;
    bit f;
    for (int i = 0; i < 4; i++) words[i] = 32'hA5000000 + 32'(i) * 32'h01010101;
    bus.req = 4'b1111;
    bus.fifo_full = 1'b0;
    bus.data_in = {words[3], words[2], words[1], words[0]};
    #12;
    do_reset();
    tbl[0]  = '{4'b0001, 1'b0, 4'b0001, 0, 1'b1};
    tbl[1]  = '{4'b1111, 1'b0, 4'b0001, 0, 1'b1};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0001, 0, 1'b1};
    tbl[3]  = '{4'b1111, 1'b0, 4'b0001, 0, 1'b1};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0010, 1, 1'b1};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 1, 1'b1};
    tbl[6]  = '{4'b0010, 1'b0, 4'b0010, 1, 1'b1};
    tbl[7]  = '{4'b1000, 1'b0, 4'b1000, 3, 1'b1};
    tbl[8]  = '{4'b0000, 1'b0, 4'b0000, 3, 1'b0};
    tbl[9]  = '{4'b0101, 1'b0, 4'b0001, 0, 1'b1};
    tbl[10] = '{4'b0100, 1'b0, 4'b0100, 2, 1'b1};
    tbl[11] = '{4'b0000, 1'b0, 4'b0000, 2, 1'b0};
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].req, tbl[i].full, a);
      chk("tbl_ack", 32'(a), 32'(tbl[i].ack));
      chk("tbl_gid", 32'(bus.grant_id), 32'(tbl[i].gid));
      chk("tbl_busy", 32'(bus.busy), 32'(tbl[i].busy));
    end
    chk("idle_data_hold", bus.fifo_data_w, words[2]);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cycle(4'b1111, 1'b0, a);
      chk("burst_order", 32'(a), 32'd1 << (i / 4));
      chk("burst_no_gap", 32'(bus.fifo_we), 32'd1);
    end
    cycle(4'b0010, 1'b0, a);
    cycle(4'b0010, 1'b0, a);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0010, 1'b1, a);
      chk("full_ack", 32'(a), 32'd0);
      chk("full_we", 32'(bus.fifo_we), 32'd0);
    end
    cycle(4'b0010, 1'b0, a);
    chk("resume_owner1", 32'(a), 32'b0010);
    cycle(4'b1000, 1'b0, a);
    chk("switch_to3", 32'(a), 32'b1000);
    chk("switch_no_bubble", 32'(bus.fifo_we), 32'd1);
    bus.req = 4'b1000;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(4'b1000, 1'b0, a);
    chk("post_reset_ack3", 32'(a), 32'b1000);
    do_reset();
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++)
        if (!r[i] && $urandom_range(1, 0) == 1) begin
          r[i] = 1'b1;
          words[i] = $urandom;
        end
      f = $urandom_range(4, 0) == 0;
      cycle(r, f, a);
      if (last_w >= 0) r[last_w] = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
